// File: rtl/poly_operand_loader.sv
// Word-serial operand loader for the polynomial register bank: streams A, B, M, M_prime_0 (mask-selected) onto the bank load port.
// Optional stall timeout enabled by defining POLY_LOADER_TIMEOUT_EN.
module poly_operand_loader #(
  parameter int WORD_WIDTH     = 17,
  parameter int N              = 5,
  parameter int S              = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  input  logic                  start_i,
  input  logic [3:0]            load_mask_i,
  input  logic [WORD_WIDTH-1:0] s_data_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  output logic [1:0]            INPUT_reg_sel_o,
  output logic                  INPUT_reg_en_o,
  output logic [WORD_WIDTH-1:0] INPUT_reg_din_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o
);

  // state | meaning
  // IDLE  | waiting for start_i
  // LOAD  | accepting stream words into the current register
  // DONE  | one-cycle done_o pulse, then back to IDLE

  localparam int CNT_W = $clog2(N*S);
  localparam logic [CNT_W-1:0] LAST_OP = CNT_W'(N*S-1);
  localparam logic [CNT_W-1:0] LAST_MP = CNT_W'(N-1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t           state;
  logic [3:0]       rem_mask;
  logic [1:0]       cur_sel;
  logic [CNT_W-1:0] word_cnt;
  logic             beat;
  logic             last_word;
  logic [3:0]       rem_next;

  function automatic logic [1:0] lowest(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  assign beat      = s_valid_i && s_ready_o;
  assign last_word = (word_cnt == ((cur_sel == 2'd3) ? LAST_MP : LAST_OP));
  assign rem_next  = rem_mask & ~(4'b0001 << cur_sel);

`ifdef POLY_LOADER_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 1);
  logic [STALL_W-1:0] stall_cnt;
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT_CYCLES > 0);
  assign error_o = 1'b0;
`endif

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state           <= IDLE;
      rem_mask        <= '0;
      cur_sel         <= '0;
      word_cnt        <= '0;
      s_ready_o       <= 1'b0;
      INPUT_reg_sel_o <= '0;
      INPUT_reg_en_o  <= 1'b0;
      INPUT_reg_din_o <= '0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
`ifdef POLY_LOADER_TIMEOUT_EN
      stall_cnt       <= '0;
      error_o         <= 1'b0;
`endif
    end else begin
      INPUT_reg_en_o <= 1'b0;
      done_o         <= 1'b0;
`ifdef POLY_LOADER_TIMEOUT_EN
      error_o        <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start_i) begin
            if (load_mask_i != 4'b0000) begin
              rem_mask  <= load_mask_i;
              cur_sel   <= lowest(load_mask_i);
              word_cnt  <= '0;
              state     <= LOAD;
              busy_o    <= 1'b1;
              s_ready_o <= 1'b1;
`ifdef POLY_LOADER_TIMEOUT_EN
              stall_cnt <= '0;
`endif
            end else begin
              state  <= DONE;
              done_o <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (beat) begin
            INPUT_reg_en_o  <= 1'b1;
            INPUT_reg_sel_o <= cur_sel;
            INPUT_reg_din_o <= s_data_i;
`ifdef POLY_LOADER_TIMEOUT_EN
            stall_cnt <= '0;
`endif
            if (last_word) begin
              word_cnt <= '0;
              rem_mask <= rem_next;
              if (rem_next == 4'b0000) begin
                // final strobe and done_o land in the same cycle
                state     <= DONE;
                done_o    <= 1'b1;
                busy_o    <= 1'b0;
                s_ready_o <= 1'b0;
              end else begin
                cur_sel <= lowest(rem_next);
              end
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
`ifdef POLY_LOADER_TIMEOUT_EN
          else if (stall_cnt == STALL_LAST) begin
            state     <= IDLE;
            error_o   <= 1'b1;
            busy_o    <= 1'b0;
            s_ready_o <= 1'b0;
            word_cnt  <= '0;
            rem_mask  <= '0;
            stall_cnt <= '0;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_poly_operand_loader.sv
// Directed bench for poly_operand_loader with a bank-port scoreboard.
module tb_poly_operand_loader;

  localparam int W = 17;

  logic          clock_i = 1'b0;
  logic          reset_n_i;
  logic          start_i;
  logic [3:0]    load_mask_i;
  logic [W-1:0]  s_data_i;
  logic          s_valid_i;
  logic          s_ready_o;
  logic [1:0]    INPUT_reg_sel_o;
  logic          INPUT_reg_en_o;
  logic [W-1:0]  INPUT_reg_din_o;
  logic          busy_o;
  logic          done_o;
  logic          error_o;

  poly_operand_loader #(.WORD_WIDTH(W), .N(5), .S(4), .TIMEOUT_CYCLES(8)) dut (
    .clock_i(clock_i), .reset_n_i(reset_n_i), .start_i(start_i), .load_mask_i(load_mask_i),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .INPUT_reg_sel_o(INPUT_reg_sel_o), .INPUT_reg_en_o(INPUT_reg_en_o),
    .INPUT_reg_din_o(INPUT_reg_din_o), .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct packed {
    logic [1:0]   sel;
    logic [W-1:0] din;
    logic         last;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int en_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  always @(negedge clock_i) begin
    if (reset_n_i) begin
      if (done_o) done_cnt++;
      if (error_o) err_cnt++;
      if (INPUT_reg_en_o) begin
        exp_t e;
        en_cnt++;
        if (sb.size() == 0) chk("unexpected_en", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          chk("sel", 32'(INPUT_reg_sel_o), 32'(e.sel));
          chk("din", 32'(INPUT_reg_din_o), 32'(e.din));
          chk("done_with_last", 32'(done_o), 32'(e.last));
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input logic [1:0] sel, input logic last);
    exp_t e;
    int n;
    s_valid_i = 1'b1;
    s_data_i  = d;
    n = 0;
    while (!s_ready_o && n < 50) begin
      @(negedge clock_i);
      n++;
    end
    if (!s_ready_o) chk("ready_timeout", 32'd0, 32'd1);
    e.sel = sel; e.din = d; e.last = last;
    sb.push_back(e);
    @(negedge clock_i);
    s_valid_i = 1'b0;
  endtask

  task automatic start_cmd(input logic [3:0] m);
    start_i = 1'b1;
    load_mask_i = m;
    @(negedge clock_i);
    start_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    #1;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clock_i);
      #1;
      n++;
    end
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int d0, e0;
    reset_n_i = 1'b0; start_i = 1'b0; load_mask_i = 4'h0; s_data_i = '0; s_valid_i = 1'b0;
    #12;
    chk("rst_en", 32'(INPUT_reg_en_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_err", 32'(error_o), 32'd0);
    chk("rst_ready", 32'(s_ready_o), 32'd0);
    chk("rst_din", 32'(INPUT_reg_din_o), 32'd0);
    @(negedge clock_i);
    reset_n_i = 1'b1;
    @(negedge clock_i);

    // full load, continuous valid
    d0 = done_cnt; e0 = en_cnt;
    start_cmd(4'b1111);
    chk("full_busy", 32'(busy_o), 32'd1);
    for (int i = 0; i < 65; i++)
      send(W'(i), (i < 20) ? 2'd0 : (i < 40) ? 2'd1 : (i < 60) ? 2'd2 : 2'd3, i == 64);
    drain("full_drain");
    chk("full_busy_end", 32'(busy_o), 32'd0);
    chk("full_done_once", 32'(done_cnt - d0), 32'd1);
    chk("full_en_count", 32'(en_cnt - e0), 32'd65);
    repeat (3) @(negedge clock_i);
    #1;
    chk("hold_sel", 32'(INPUT_reg_sel_o), 32'd3);
    chk("hold_din", 32'(INPUT_reg_din_o), 32'd64);
    chk("hold_en", 32'(INPUT_reg_en_o), 32'd0);
    chk("full_done_still_once", 32'(done_cnt - d0), 32'd1);

    // sparse mask B + M_prime_0, with an ignored start mid-command
    d0 = done_cnt; e0 = en_cnt;
    start_cmd(4'b1010);
    for (int i = 0; i < 25; i++) begin
      if (i == 5) begin start_i = 1'b1; load_mask_i = 4'b0001; end
      send(W'(200 + i), (i < 20) ? 2'd1 : 2'd3, i == 24);
      start_i = 1'b0;
    end
    drain("sparse_drain");
    repeat (2) @(negedge clock_i);
    #1;
    chk("sparse_done_once", 32'(done_cnt - d0), 32'd1);
    chk("sparse_en_count", 32'(en_cnt - e0), 32'd25);
    chk("sparse_busy", 32'(busy_o), 32'd0);

    // backpressure on A: one idle cycle after each word
    d0 = done_cnt; e0 = en_cnt;
    start_cmd(4'b0001);
    for (int i = 0; i < 20; i++) begin
      send(W'(300 + i), 2'd0, i == 19);
      if (i < 19) begin
        #1;
        chk("bp_busy", 32'(busy_o), 32'd1);
        @(negedge clock_i);
        #1;
        chk("bp_en_idle", 32'(INPUT_reg_en_o), 32'd0);
      end
    end
    drain("bp_drain");
    chk("bp_done_once", 32'(done_cnt - d0), 32'd1);
    chk("bp_en_count", 32'(en_cnt - e0), 32'd20);

    // empty mask
    @(negedge clock_i);
    e0 = en_cnt;
    start_cmd(4'b0000);
    #1;
    chk("m0_done", 32'(done_o), 32'd1);
    chk("m0_busy", 32'(busy_o), 32'd0);
    chk("m0_en", 32'(INPUT_reg_en_o), 32'd0);
    @(negedge clock_i);
    #1;
    chk("m0_done_clear", 32'(done_o), 32'd0);
    chk("m0_no_en", 32'(en_cnt - e0), 32'd0);

    // mid-command reset after 7 A words
    d0 = done_cnt;
    start_cmd(4'b0001);
    for (int i = 0; i < 7; i++) send(W'(400 + i), 2'd0, 1'b0);
    drain("mr_drain");
    #2;
    reset_n_i = 1'b0;
    #1;
    chk("mr_en", 32'(INPUT_reg_en_o), 32'd0);
    chk("mr_busy", 32'(busy_o), 32'd0);
    chk("mr_ready", 32'(s_ready_o), 32'd0);
    chk("mr_din", 32'(INPUT_reg_din_o), 32'd0);
    chk("mr_sel", 32'(INPUT_reg_sel_o), 32'd0);
    @(negedge clock_i);
    reset_n_i = 1'b1;
    @(negedge clock_i);
    chk("mr_no_done", 32'(done_cnt - d0), 32'd0);
    e0 = en_cnt;
    start_cmd(4'b0001);
    for (int i = 0; i < 20; i++) send(W'(500 + i), 2'd0, i == 19);
    drain("mr_reload_drain");
    chk("mr_reload_done", 32'(done_cnt - d0), 32'd1);
    chk("mr_reload_en", 32'(en_cnt - e0), 32'd20);

    // stall after 3 words
    @(negedge clock_i);
    d0 = done_cnt; e0 = err_cnt;
    start_cmd(4'b0001);
    for (int i = 0; i < 3; i++) send(W'(600 + i), 2'd0, 1'b0);
`ifdef POLY_LOADER_TIMEOUT_EN
    repeat (7) @(negedge clock_i);
    #1;
    chk("to_err_early", 32'(error_o), 32'd0);
    chk("to_busy_early", 32'(busy_o), 32'd1);
    @(negedge clock_i);
    #1;
    chk("to_err_pulse", 32'(error_o), 32'd1);
    chk("to_busy_cleared", 32'(busy_o), 32'd0);
    chk("to_done_low", 32'(done_o), 32'd0);
    @(negedge clock_i);
    #1;
    chk("to_err_one_cycle", 32'(error_o), 32'd0);
    chk("to_ready_low", 32'(s_ready_o), 32'd0);
    chk("to_sb_empty", 32'(sb.size()), 32'd0);
`else
    repeat (20) @(negedge clock_i);
    #1;
    chk("stall_busy", 32'(busy_o), 32'd1);
    chk("stall_err", 32'(err_cnt - e0), 32'd0);
    for (int i = 3; i < 20; i++) send(W'(600 + i), 2'd0, i == 19);
    drain("stall_drain");
    chk("stall_done", 32'(done_cnt - d0), 32'd1);
`endif
    repeat (3) @(negedge clock_i);
    chk("final_err_cnt", 32'(err_cnt - e0),
`ifdef POLY_LOADER_TIMEOUT_EN
        32'd1);
    chk("final_no_done", 32'(done_cnt - d0), 32'd0);
`else
        32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
